// File: rtl/mdl_noise_pkg.sv
// Shared constants and helpers for the noise generator slice.
package mdl_pkg;

  localparam int unsigned LFSR_W         = 17;
  localparam int unsigned TAP_IDX        = 3;
  localparam int unsigned SER_W          = 16;
  localparam int unsigned TST_NOISE_STEP = 3;

  typedef logic [LFSR_W-1:0] lfsr_t;

  // XNOR feedback keeps all-zero a live state instead of a lock-up state.
  function automatic lfsr_t lfsr_advance(input lfsr_t v);
    return {~(v[0] ^ v[TAP_IDX]), v[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/mdl_noise_if.sv
// Bundle of the noise generator's frame/control inputs and noise outputs.
interface mdl_noise_if;
  import mdl_pkg::*;

  logic       pcen_n;
  logic       ncen_n;
  logic       cycle_12_28;
  logic       cycle_15_31;
  logic [4:0] nfrq;
  logic       ne;
  logic [7:0] test;
  logic       noise_serial;
  logic       noise_bit;
  logic       noise_step;
  lfsr_t      lfsr;

  modport master (
    output pcen_n, ncen_n, cycle_12_28, cycle_15_31, nfrq, ne, test,
    input  noise_serial, noise_bit, noise_step, lfsr
  );

  modport slave (
    input  pcen_n, ncen_n, cycle_12_28, cycle_15_31, nfrq, ne, test,
    output noise_serial, noise_bit, noise_step, lfsr
  );
endinterface

// File: rtl/mdl_noise_lfsr.sv
// 17-bit XNOR-feedback LFSR; advances when both enable and step are high.
module mdl_noise_lfsr
  import mdl_pkg::*;
#(
  parameter lfsr_t P_SEED = '0
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  en_i,
  input  logic  step_i,
  output lfsr_t lfsr_o,
  output lfsr_t lfsr_next_o
);

  lfsr_t lfsr_q, lfsr_d;

  assign lfsr_next_o = lfsr_advance(lfsr_q);

  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i && step_i) lfsr_d = lfsr_next_o;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= P_SEED;
    else         lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/mdl_noise.sv
// YM2151-style noise generator: NFRQ divider, LFSR stepping, slot-32 bit and serial feed to the LFO.
module mdl_noise
  import mdl_pkg::*;
#(
  parameter lfsr_t P_LFSR_SEED = 17'h00000
) (
  input  logic        i_EMUCLK,
  input  logic        i_MRST_n,
  input  logic        i_phi1_PCEN_n,
  input  logic        i_phi1_NCEN_n,
  input  logic        i_CYCLE_12_28,
  input  logic        i_CYCLE_15_31,
  input  logic [4:0]  i_NFRQ,
  input  logic        i_NE,
  input  logic [7:0]  i_TEST,
  output logic        o_NOISE_SERIAL,
  output logic        o_NOISE_BIT,
  output logic        o_NOISE_STEP,
  output logic [16:0] o_LFSR
);

  logic             en;
  logic             step;
  logic [4:0]       cntr_q, cntr_d;
  logic [SER_W-1:0] snap_q, snap_d;
  logic             serial_q, serial_d;
  logic             bit_q, bit_d;
  logic             step_q, step_d;
  lfsr_t            lfsr_q, lfsr_next;
  logic             unused_inputs;

  assign en            = !i_phi1_NCEN_n;
  assign unused_inputs = ^{i_phi1_PCEN_n, i_TEST[7:4], i_TEST[2:0]};

  mdl_noise_lfsr #(
    .P_SEED (P_LFSR_SEED)
  ) u_lfsr (
    .clk_i       (i_EMUCLK),
    .rst_ni      (i_MRST_n),
    .en_i        (en),
    .step_i      (step),
    .lfsr_o      (lfsr_q),
    .lfsr_next_o (lfsr_next)
  );

  // Divider only compares for equality, so a target below cntr is reached via the 31->0 wrap.
  always_comb begin
    cntr_d = cntr_q;
    step   = 1'b0;
    if (i_CYCLE_12_28) begin
      if (cntr_q == ~i_NFRQ) begin
        cntr_d = '0;
        step   = 1'b1;
      end else begin
        cntr_d = cntr_q + 5'd1;
      end
    end
    if (i_TEST[TST_NOISE_STEP]) step = 1'b1;
  end

  always_comb begin
    snap_d = {1'b0, snap_q[SER_W-1:1]};
    if (i_CYCLE_15_31) snap_d = step ? lfsr_next[SER_W-1:0] : lfsr_q[SER_W-1:0];
    serial_d = snap_q[0];
    bit_d    = lfsr_q[0] & i_NE;
    step_d   = step;
  end

  always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) begin
      cntr_q   <= '0;
      snap_q   <= '0;
      serial_q <= 1'b0;
      bit_q    <= 1'b0;
      step_q   <= 1'b0;
    end else if (en) begin
      cntr_q   <= cntr_d;
      snap_q   <= snap_d;
      serial_q <= serial_d;
      bit_q    <= bit_d;
      step_q   <= step_d;
    end
  end

  assign o_NOISE_SERIAL = serial_q;
  assign o_NOISE_BIT    = bit_q;
  assign o_NOISE_STEP   = step_q;
  assign o_LFSR         = lfsr_q;

endmodule

// File: doc/mdl_noise.md
Name: mdl_noise

Overview:
- YM2151-compatible noise generator.
- Divides the sample-frame timing by a 5-bit NFRQ-controlled counter and steps a 17-bit LFSR on each terminal count.
- Feeds two consumers: the LFO, which receives a serial noise stream for its phase accumulator when waveform W=3, and the operator output stage, which receives the slot-32 noise bit.
- Sits directly upstream of mdl_lfo.

Parameters:
- P_LFSR_SEED, 17'h00000, LFSR value loaded on reset. XNOR feedback makes all-zero a legal, non-locking state.

Ports:
- i_EMUCLK  in  1  emulator master clock
- i_MRST_n  in  1  asynchronous active-low reset
- i_phi1_PCEN_n  in  1  phi1 positive-edge clock enable, active low
- i_phi1_NCEN_n  in  1  phi1 negative-edge clock enable, active low
- i_CYCLE_12_28  in  1  frame timing pulse; advances the divider
- i_CYCLE_15_31  in  1  frame timing pulse; loads the serial snapshot
- i_NFRQ  in  5  noise frequency register
- i_NE  in  1  noise enable, slot 32
- i_TEST  in  8  test register; bit 3 forces an LFSR step on every enable
- o_NOISE_SERIAL  out  1  serial noise stream to LFO, LSB first
- o_NOISE_BIT  out  1  registered noise bit for slot-32 output, gated by NE
- o_NOISE_STEP  out  1  one-enable pulse marking an LFSR step
- o_LFSR  out  17  debug view of LFSR

Behaviour:
- Clocking: all state updates on posedge i_EMUCLK qualified by !i_phi1_NCEN_n. i_phi1_PCEN_n is unused and reserved.
- Reset: asynchronous on !i_MRST_n.
  - divider = 0, LFSR = P_LFSR_SEED, snapshot = 0.
  - All outputs 0, except o_LFSR = P_LFSR_SEED.
  - Reset may assert mid-frame or mid-shift. State clears immediately; no partial serial word survives.
- Divider:
  - 5-bit cntr; target = ~i_NFRQ.
  - On enable with i_CYCLE_12_28 = 1:
    - if cntr == target: cntr <= 0 and step is asserted for this enable;
    - else cntr <= cntr + 1, wrapping 31 -> 0.
  - Step period is (32 - NFRQ) pulses. NFRQ = 31 gives a step on every pulse; NFRQ = 0 gives a step every 32 pulses.
  - If NFRQ changes so that cntr > target, cntr continues counting through 31 -> 0 to the new target. There is no early reset.
- Test: i_TEST[3] = 1 asserts step on every enable regardless of timing. The divider keeps counting normally.
- LFSR step:
  - Update: lfsr <= {~(lfsr[0] ^ lfsr[3]), lfsr[16:1]}.
  - From 0, the first step gives 17'h10000; the sequence has maximal length 2^17 - 1.
- o_NOISE_STEP: registered copy of step, one enable late.
- o_NOISE_BIT:
  - Registered lfsr[0] & i_NE, updated every enable.
  - Shows the post-step LSB one enable after the step.
- Serial path:
  - On enable with i_CYCLE_15_31 = 1: snap <= lfsr[15:0] (post-step value if both occur on the same enable).
  - Otherwise snap <= {1'b0, snap[15:1]}.
  - o_NOISE_SERIAL = snap[0], registered. Bit 0 of the loaded word appears on the enable after the load; bit n appears n enables later.
  - Zeros fill after 16 bits.
  - A new i_CYCLE_15_31 before 16 shifts truncates the old word.
- Simultaneous events: step and snapshot load on the same enable -> the snapshot takes the new LFSR value. Step and reset -> reset wins.
- o_LFSR: registered mirror of lfsr.

Decomposition:
- Shared package mdl_pkg holds:
  - LFSR width constant 17;
  - tap index constant 3;
  - serial width 16;
  - TEST bit index constants (TST_NOISE_STEP = 3).
- One natural sub-module: mdl_noise_lfsr. It contains the 17-bit register, XNOR feedback and step input, with a parallel output. The divider and serializer stay in the top.

Test Plan:
- Reset with seed 0, NFRQ = 31, 64 pulses of i_CYCLE_12_28 -> 64 steps; first o_LFSR values 17'h10000, 17'h18000, 17'h1C000.
- NFRQ = 0 -> exactly one o_NOISE_STEP per 32 i_CYCLE_12_28 pulses; NFRQ = 28 -> one step per 4 pulses.
- NFRQ changed from 0 to 31 while cntr = 10 -> cntr wraps through 31 -> 0, then steps every pulse thereafter.
- Snapshot with LFSR = 17'h0A5C3 at i_CYCLE_15_31 -> o_NOISE_SERIAL emits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1, then zeros.
- i_TEST[3] = 1 for 20 enables -> 20 consecutive steps. NE = 0 -> o_NOISE_BIT held 0 while o_LFSR advances.
- Assert i_MRST_n low mid-serial-shift and mid-count -> all outputs 0 and o_LFSR = seed immediately. After release, the first step occurs after a full (32 - NFRQ) pulses.
